// File: rtl/apple1_bus_decoder.sv
// apple1_bus_decoder: mask/base region decoder, CPU data-in mux, wait-state generator
// and bus-error reporting between the 6502 core and its memory/peripherals.
module apple1_bus_decoder #(
  parameter int                 NREG    = 5,
  parameter int                 AW      = 16,
  parameter int                 DW      = 8,
  parameter logic [NREG*AW-1:0] BASE    = {16'hFF00, 16'hE000, 16'hD012, 16'hD010, 16'h0000},
  parameter logic [NREG*AW-1:0] MASK    = {16'hFF00, 16'hF000, 16'hFFFE, 16'hFFFE, 16'hE000},
  parameter logic [NREG*4-1:0]  WAIT    = {NREG{4'd0}},
  parameter logic [NREG-1:0]    RO      = 5'b11000,
  parameter logic [DW-1:0]      UNMAP_D = 8'hFF
) (
  input  logic               clk14,
  input  logic               rst_n,
  input  logic               cpu_clken,
  input  logic [AW-1:0]      ab,
  input  logic               we,
  input  logic [NREG*DW-1:0] dev_dout,
  output logic [DW-1:0]      dbi,
  output logic               ready,
  output logic [NREG-1:0]    cs,
  output logic [NREG-1:0]    dev_we,
  output logic               bus_err,
  output logic [7:0]         err_cnt,
  output logic [AW-1:0]      err_addr
);
  typedef enum logic {S_IDLE, S_WAIT} state_t;
  state_t          r_state, w_nstate;
  logic [3:0]      r_cnt, w_ncnt;
  logic [NREG-1:0] w_hit, w_sel;
  logic [DW-1:0]   w_dbi;
  logic [3:0]      w_wsel;
  logic            w_ro, w_err;
  logic            r_bus_err;
  logic [7:0]      r_err_cnt;
  logic [AW-1:0]   r_err_addr;
  for (genvar g = 0; g < NREG; g++) begin : g_hit
    assign w_hit[g] = (ab & MASK[g*AW+:AW]) == BASE[g*AW+:AW];
  end
  // Walk from the top index down so the lowest hitting region is the last writer.
  always_comb begin
    w_sel  = '0;
    w_dbi  = UNMAP_D;
    w_wsel = 4'd0;
    w_ro   = 1'b0;
    for (int i = NREG - 1; i >= 0; i--) begin
      if (w_hit[i]) begin
        w_sel    = '0;
        w_sel[i] = 1'b1;
        w_dbi    = dev_dout[i*DW+:DW];
        w_wsel   = WAIT[i*4+:4];
        w_ro     = RO[i];
      end
    end
  end
  assign cs     = w_sel;
  assign dbi    = w_dbi;
  assign ready  = (r_state == S_IDLE) ? (w_wsel == 4'd0) : (r_cnt == 4'd0);
  assign dev_we = w_sel & ~RO & {NREG{we & ready}};
  assign w_err  = cpu_clken & ready & (~|w_hit | (we & w_ro));
  always_comb begin
    w_nstate = r_state;
    w_ncnt   = r_cnt;
    if (cpu_clken) begin
      if (r_state == S_IDLE) begin
        if (w_wsel != 4'd0) begin
          w_nstate = S_WAIT;
          w_ncnt   = w_wsel - 4'd1;
        end
      end else if (r_cnt == 4'd0) begin
        w_nstate = S_IDLE;
      end else begin
        w_ncnt = r_cnt - 4'd1;
      end
    end
  end
  always_ff @(posedge clk14 or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= S_IDLE;
      r_cnt      <= 4'd0;
      r_bus_err  <= 1'b0;
      r_err_cnt  <= 8'd0;
      r_err_addr <= '0;
    end else begin
      r_state   <= w_nstate;
      r_cnt     <= w_ncnt;
      r_bus_err <= w_err;
      if (w_err) begin
        r_err_addr <= ab;
        r_err_cnt  <= (r_err_cnt == 8'hFF) ? r_err_cnt : r_err_cnt + 8'd1;
      end
    end
  end
  assign bus_err  = r_bus_err;
  assign err_cnt  = r_err_cnt;
  assign err_addr = r_err_addr;
endmodule

// File: tb/tb_apple1_bus_decoder.sv
// tb_apple1_bus_decoder: scoreboard bench over three decoder instances
// (stock map, region3 with 3 wait states, overlapping region1).
module tb_apple1_bus_decoder;
  typedef struct {
    int         d;
    logic       r;
    logic [4:0] c;
    logic [7:0] db;
    logic [4:0] w;
  } exp_t;
  typedef struct {
    logic [15:0] a;
    logic [7:0]  c;
  } err_t;
  logic        clk14 = 1'b0;
  logic        rst_n = 1'b0;
  logic        cpu_clken = 1'b0;
  logic [15:0] ab = 16'h0123;
  logic        we = 1'b0;
  logic [39:0] dev_dout = {8'h44, 8'h33, 8'h22, 8'h11, 8'hA5};
  logic [2:0]        rdy_v, berr_v;
  logic [2:0][7:0]   dbi_v, ecnt_v;
  logic [2:0][4:0]   cs_v, we_v;
  logic [2:0][15:0]  eaddr_v;
  exp_t sb[$];
  err_t errq[$];
  exp_t me;
  err_t mr;
  int total = 0;
  int bad = 0;
  int nerr = 0;
  always #5 clk14 = ~clk14;
  apple1_bus_decoder u_def (
    .clk14(clk14), .rst_n(rst_n), .cpu_clken(cpu_clken), .ab(ab), .we(we), .dev_dout(dev_dout),
    .dbi(dbi_v[0]), .ready(rdy_v[0]), .cs(cs_v[0]), .dev_we(we_v[0]),
    .bus_err(berr_v[0]), .err_cnt(ecnt_v[0]), .err_addr(eaddr_v[0]));
  apple1_bus_decoder #(.WAIT(20'h03000)) u_wt (
    .clk14(clk14), .rst_n(rst_n), .cpu_clken(cpu_clken), .ab(ab), .we(we), .dev_dout(dev_dout),
    .dbi(dbi_v[1]), .ready(rdy_v[1]), .cs(cs_v[1]), .dev_we(we_v[1]),
    .bus_err(berr_v[1]), .err_cnt(ecnt_v[1]), .err_addr(eaddr_v[1]));
  apple1_bus_decoder #(
    .BASE({16'hFF00, 16'hE000, 16'hD012, 16'h0000, 16'h0000}),
    .MASK({16'hFF00, 16'hF000, 16'hFFFE, 16'hE000, 16'hE000})
  ) u_ov (
    .clk14(clk14), .rst_n(rst_n), .cpu_clken(cpu_clken), .ab(ab), .we(we), .dev_dout(dev_dout),
    .dbi(dbi_v[2]), .ready(rdy_v[2]), .cs(cs_v[2]), .dev_we(we_v[2]),
    .bus_err(berr_v[2]), .err_cnt(ecnt_v[2]), .err_addr(eaddr_v[2]));
  task automatic chk(input string n, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", n, got, exp);
    end
  endtask
  // One CPU step: queue the expected bus view, strobe once, then one idle clk14.
  task automatic acc(input int d, input logic [15:0] a, input logic w, input logic r,
                     input logic [4:0] c, input logic [7:0] db, input logic [4:0] dw, input bit e);
    ab = a;
    we = w;
    sb.push_back('{d, r, c, db, dw});
    if (e) begin
      nerr++;
      errq.push_back('{a, (nerr > 255) ? 8'hFF : 8'(nerr)});
    end
    cpu_clken = 1'b1;
    @(posedge clk14) #1;
    cpu_clken = 1'b0;
    @(posedge clk14) #1;
  endtask
  always @(negedge clk14) begin
    if (cpu_clken) begin
      total++;
      if (sb.size() == 0) begin
        bad++;
        $display("FAIL acc: strobe with empty scoreboard ab=%h", ab);
      end else begin
        me = sb.pop_front();
        if ({rdy_v[me.d], cs_v[me.d], dbi_v[me.d], we_v[me.d]} !== {me.r, me.c, me.db, me.w}) begin
          bad++;
          $display("FAIL acc d%0d ab=%h: got rdy=%b cs=%b dbi=%h we=%b want rdy=%b cs=%b dbi=%h we=%b",
                   me.d, ab, rdy_v[me.d], cs_v[me.d], dbi_v[me.d], we_v[me.d], me.r, me.c, me.db, me.w);
        end
      end
    end
    if (berr_v[0] === 1'b1) begin
      total++;
      if (errq.size() == 0) begin
        bad++;
        $display("FAIL bus_err: unexpected pulse err_addr=%h", eaddr_v[0]);
      end else begin
        mr = errq.pop_front();
        if ({eaddr_v[0], ecnt_v[0]} !== {mr.a, mr.c}) begin
          bad++;
          $display("FAIL bus_err: got addr=%h cnt=%h want addr=%h cnt=%h", eaddr_v[0], ecnt_v[0], mr.a, mr.c);
        end
      end
    end
  end
  initial begin
    #12;
    chk("rst_bus_err", 32'(berr_v[0]), 32'd0);
    chk("rst_err_cnt", 32'(ecnt_v[0]), 32'd0);
    chk("rst_err_addr", 32'(eaddr_v[0]), 32'd0);
    chk("rst_view", {rdy_v[0], cs_v[0], dbi_v[0]}, {1'b1, 5'b00001, 8'hA5});
    @(posedge clk14) #1;
    rst_n = 1'b1;
    @(posedge clk14) #1;
    for (int i = 0; i < 3; i++) acc(0, 16'h0123, 1'b0, 1'b1, 5'b00001, 8'hA5, 5'b00000, 1'b0);
    acc(0, 16'h0123, 1'b1, 1'b1, 5'b00001, 8'hA5, 5'b00001, 1'b0);
    acc(0, 16'hD010, 1'b0, 1'b1, 5'b00010, 8'h11, 5'b00000, 1'b0);
    acc(0, 16'hD013, 1'b0, 1'b1, 5'b00100, 8'h22, 5'b00000, 1'b0);
    acc(0, 16'hD012, 1'b1, 1'b1, 5'b00100, 8'h22, 5'b00100, 1'b0);
    for (int i = 0; i < 3; i++) acc(1, 16'hE000, 1'b0, 1'b0, 5'b01000, 8'h33, 5'b00000, 1'b0);
    acc(1, 16'hE000, 1'b0, 1'b1, 5'b01000, 8'h33, 5'b00000, 1'b0);
    acc(1, 16'h0123, 1'b0, 1'b1, 5'b00001, 8'hA5, 5'b00000, 1'b0);
    acc(0, 16'hFF00, 1'b1, 1'b1, 5'b10000, 8'h44, 5'b00000, 1'b1);
    acc(0, 16'h8000, 1'b0, 1'b1, 5'b00000, 8'hFF, 5'b00000, 1'b1);
    acc(0, 16'h8000, 1'b1, 1'b1, 5'b00000, 8'hFF, 5'b00000, 1'b1);
    acc(2, 16'h0010, 1'b0, 1'b1, 5'b00001, 8'hA5, 5'b00000, 1'b0);
    for (int i = 0; i < 300; i++)
      acc(0, 16'h8000 + 16'(i), 1'b0, 1'b1, 5'b00000, 8'hFF, 5'b00000, 1'b1);
    chk("err_cnt_sat", 32'(ecnt_v[0]), 32'hFF);
    chk("err_addr_last", 32'(eaddr_v[0]), 32'h812B);
    acc(1, 16'hE000, 1'b0, 1'b0, 5'b01000, 8'h33, 5'b00000, 1'b0);
    #2;
    ab = 16'h0123;
    chk("wait_ready_before_rst", 32'(rdy_v[1]), 32'd0);
    rst_n = 1'b0;
    #1;
    chk("rst_mid_wait_ready", 32'(rdy_v[1]), 32'd1);
    chk("rst_mid_err_cnt", 32'(ecnt_v[0]), 32'd0);
    chk("rst_mid_err_addr", 32'(eaddr_v[0]), 32'd0);
    @(posedge clk14) #1;
    rst_n = 1'b1;
    nerr = 0;
    @(posedge clk14) #1;
    for (int i = 0; i < 3; i++) acc(1, 16'hE000, 1'b0, 1'b0, 5'b01000, 8'h33, 5'b00000, 1'b0);
    acc(1, 16'hE000, 1'b0, 1'b1, 5'b01000, 8'h33, 5'b00000, 1'b0);
    acc(0, 16'h9000, 1'b0, 1'b1, 5'b00000, 8'hFF, 5'b00000, 1'b1);
    repeat (3) @(posedge clk14);
    #1;
    chk("err_cnt_after_rst", 32'(ecnt_v[0]), 32'd1);
    chk("sb_drained", 32'(sb.size()), 32'd0);
    chk("errq_drained", 32'(errq.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
